reg_write_arbiter: RTL

Round-robin write arbiter that shares one WIDTH-bit storage register (a bank of D flip-flops) between N requesters. Each requester presents a write request and data. The arbiter grants one requester at a time, captures its data into the shared register, and returns a one-cycle acknowledge. It sits in front of any shared state register that more than one sequential block needs to update.

---
 rtl/reg_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter sharing one WIDTH-bit register
// among N requesters. Each write takes GRANT (capture) then ACK (pulse).
// Optional feature macro: REG_ARB_LOCK_EN adds a per-requester lock input that
// lets the current winner keep the register for another write without arbitration.
module reg_write_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
`ifdef REG_ARB_LOCK_EN
  input  logic [N-1:0]       lock,
`endif
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   q,
  output logic               valid,
  output logic               busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     eligible;
  logic [IW:0]      pick_idle;
  logic [IW:0]      pick_ack;
  logic             relock;

  // Returns {found, index} of the first set bit of vec searching upward from p+1, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] vec, input logic [IW-1:0] p);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    int unsigned   k_idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      k_idx = (32'(p) + k) % N;
      sel   = IW'(k_idx);
      if (!found && vec[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
    return {found, idx};
  endfunction

`ifdef REG_ARB_LOCK_EN
  assign relock = lock[win_q] & req[win_q];
`else
  assign relock = 1'b0;
`endif

  // The just-acked requester is masked so a held req cannot win twice in a row.
  assign eligible  = req & ~(N'(1) << win_q);
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_ack  = rr_pick(eligible, win_q);

  // Next-state, grant/ack and register capture decode.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    ack_d   = '0;
    q_d     = q_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_idle[IW]) begin
          state_d = ST_GRANT;
          win_d   = pick_idle[IW-1:0];
          gnt_d   = N'(1) << pick_idle[IW-1:0];
        end
      end
      ST_GRANT: begin
        // Commits regardless of req[win] so a granted write is never lost.
        q_d     = din[32'(win_q)*WIDTH +: WIDTH];
        valid_d = 1'b1;
        state_d = ST_ACK;
        ack_d   = N'(1) << win_q;
      end
      ST_ACK: begin
        ptr_d = win_q;
        if (relock) begin
          state_d = ST_GRANT;
          gnt_d   = N'(1) << win_q;
        end else if (pick_ack[IW]) begin
          state_d = ST_GRANT;
          win_d   = pick_ack[IW-1:0];
          gnt_d   = N'(1) << pick_ack[IW-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; ptr resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      ptr_q   <= IW'(N - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign q     = q_q;
  assign valid = valid_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
